instr_prefetch_unit: RTL and testbench
======================================

// Module: instr_prefetch_unit
// PURPOSE
//  Parametrised successor to the core's inline FETCH_START/FETCH_END fetch sequence.
//  Streams instruction bytes from byte-wide synchronous RAM and assembles them big-endian.
//  Buffers up to QUEUE_DEPTH decoded-ready instructions, each tagged with its PC.
//  Supports redirect (jump/ISR/reti) with a full flush; sits between RAM read port and exec core.
// PARAMETERS
//  ADDR_BITS    8  byte address width (= MEMORY_ADDRESS_BITS)
//  BYTE_BITS    8  RAM data width (= MEMORY_DATA_BITS)
//  INSTR_BYTES  2  bytes per instruction, >=1
//  QUEUE_DEPTH  4  instruction queue entries, power of 2, >=2
//  RESET_PC     0  fetch address after reset
// PORTS
//  clk             in   1                      system clock
//  reset           in   1                      asynchronous, active-high reset
//  rd_ram_en       out  1                      RAM read strobe
//  rd_ram_addr     out  ADDR_BITS              RAM read address
//  rd_ram_data     in   BYTE_BITS              read data, valid the cycle after rd_ram_en
//  redirect_valid  in   1                      flush queue and restart fetch at redirect_pc
//  redirect_pc     in   ADDR_BITS              new fetch address
//  instr_valid     out  1                      queue head valid
//  instr           out  INSTR_BYTES*BYTE_BITS  queue head; first byte in MSBs
//  instr_pc        out  ADDR_BITS              address of first byte of instr
//  instr_ready     in   1                      consumer pops head when instr_valid & instr_ready
//  queue_count     out  $clog2(QUEUE_DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (async, any time, incl. mid-assembly)
//   - Outputs rd_ram_en=0, rd_ram_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue_count=0.
//   - Internal: fetch_pc=RESET_PC, byte_idx=0, pending=0, state=FETCH_RUN.
//  Read pipeline
//   - Issue in cycle N: rd_ram_en=1, rd_ram_addr=fetch_pc; fetch_pc+1 wraps mod 2^ADDR_BITS.
//   - Byte returns in N+1 into slot byte_idx; byte 0 goes to MSBs.
//   - On final byte, push {start_pc, instr} at that edge; byte_idx->0, pending->0.
//  Reservation
//   - New instruction's first byte issues only if queue_count + pending < QUEUE_DEPTH.
//   - pending is set on that issue and reserves one slot.
//   - Pop in the same cycle is not credited (conservative).
//   - Once started, remaining bytes issue back-to-back.
//   - Queue never overflows; push onto a full queue is a design error (assertion).
//  Throughput and latency
//   - Steady state: one instruction per INSTR_BYTES cycles.
//   - First instr_valid after reset release or redirect: cycle T+INSTR_BYTES+2 (T = reset-release/redirect cycle).
//  Queue: show-ahead FIFO; instr_valid = (queue_count != 0); head registered.
//  Redirect (cycle T), highest priority
//   - Flushes queue and discards any in-flight byte (data arriving T+1 ignored).
//   - Clears byte_idx/pending; fetch_pc <= redirect_pc; push and pop in T are dropped.
//   - instr_valid=0 from T+1; first issue at T+1, rd_ram_addr=redirect_pc.
//   - Back-to-back redirects: the last one wins.
//  FSM (fetch_state_t)
//   - FETCH_RUN -> FETCH_STALL when reservation fails.
//   - FETCH_STALL -> FETCH_RUN when a slot frees or on redirect.
//   - rd_ram_en=0 in FETCH_STALL.
//  Boundaries
//   - fetch_pc wrap 0xFF->0x00 mid-instruction is legal; instr_pc keeps the start address.
//   - Simultaneous push+pop on a full queue: count unchanged.
// STRUCTURE
//  constants_pkg: fetch_state_t enum; MEMORY_ADDRESS_BITS, MEMORY_DATA_BITS, ISR_ADDRESS reused as defaults.
//  Sub-module sync_fifo #(WIDTH, DEPTH): show-ahead, push/pop/flush/count, async active-high reset.
//   - Instantiated once as instr_queue with WIDTH = ADDR_BITS + INSTR_BYTES*BYTE_BITS.
//  Top level holds fetch FSM, byte assembler, reservation logic, redirect/discard flag.
// TESTING
//  1 Reset release, RAM[0..3]=12 34 56 78, ready=1
//    -> instr=0x1234 pc=0 valid at cycle 4; instr=0x5678 pc=2 valid at cycle 6.
//  2 ready=0, DEPTH=4, sequential code
//    -> exactly 4 instrs queued, queue_count=4, rd_ram_en=0 stall.
//    -> After one pop: next instr (pc=8) appears 4 cycles later.
//  3 Redirect to 0x40 while byte 0 of pc=6 is in flight
//    -> stale byte dropped; next head instr_pc=0x40 with RAM[40:41], valid T+4; count=0 at T+1.
//  4 Redirect in same cycle as pop and push
//    -> queue empty at T+1; no instr from old stream ever appears.
//  5 Start fetch at 0xFF (redirect), RAM[FF]=AB, RAM[00]=CD
//    -> instr=0xABCD, instr_pc=0xFF.
//  6 Assert reset mid-assembly (byte_idx=1)
//    -> all outputs at reset values that cycle; after release, refetch from RESET_PC with correct data.

Source files
------------

// File: rtl/instr_prefetch_unit_pkg.sv
// Shared constants and types for the instruction prefetch path.
// Memory geometry matches the core's byte-wide program RAM.
package instr_prefetch_unit_pkg;

    localparam int MEMORY_ADDRESS_BITS = 8;
    localparam int MEMORY_DATA_BITS    = 8;
    localparam logic [MEMORY_ADDRESS_BITS-1:0] ISR_ADDRESS = 8'h04;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_STALL = 1'b1
    } fetch_state_t;

    // Index width for a counter over n items, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_prefetch_unit_fifo.sv
// Show-ahead synchronous FIFO with flush; head entry is read straight from the
// storage flops so it is valid in the same cycle the count becomes non-zero.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                full;
    logic                do_push;
    logic                do_pop;

    assign full      = (count_q == CNT_BITS'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && (count_q != '0);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PTR_BITS{1'b0}}, do_push} - {{PTR_BITS{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream reservation guarantees a free slot for every push.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full && !pop && !flush));
        end
    end

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: streams bytes from synchronous program RAM, assembles
// big-endian instructions tagged with their PC, and queues them for the core.
module instr_prefetch_unit
    import instr_prefetch_unit_pkg::*;
#(
    parameter int                   ADDR_BITS   = MEMORY_ADDRESS_BITS,
    parameter int                   BYTE_BITS   = MEMORY_DATA_BITS,
    parameter int                   INSTR_BYTES = 2,
    parameter int                   QUEUE_DEPTH = 4,
    parameter logic [ADDR_BITS-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             rd_ram_en,
    output logic [ADDR_BITS-1:0]             rd_ram_addr,
    input  logic [BYTE_BITS-1:0]             rd_ram_data,
    input  logic                             redirect_valid,
    input  logic [ADDR_BITS-1:0]             redirect_pc,
    output logic                             instr_valid,
    output logic [INSTR_BYTES*BYTE_BITS-1:0] instr,
    output logic [ADDR_BITS-1:0]             instr_pc,
    input  logic                             instr_ready,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

    localparam int INSTR_BITS = INSTR_BYTES * BYTE_BITS;
    localparam int ENTRY_BITS = ADDR_BITS + INSTR_BITS;
    localparam int CNT_BITS   = $clog2(QUEUE_DEPTH) + 1;
    localparam int IDX_BITS   = idx_bits(INSTR_BYTES);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(INSTR_BYTES - 1);

    fetch_state_t          state_q, state_d;
    logic                  armed_q, armed_d;
    logic [ADDR_BITS-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_BITS-1:0]  start_pc_q, start_pc_d;
    logic [IDX_BITS-1:0]   issue_idx_q, issue_idx_d;
    logic [IDX_BITS-1:0]   byte_idx_q, byte_idx_d;
    logic                  pending_q, pending_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [INSTR_BITS-1:0] asm_q, asm_d;

    logic                  reserve_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [ENTRY_BITS-1:0] push_data;
    logic [ENTRY_BITS-1:0] head_data;
    logic [CNT_BITS:0]     occupancy;

    // Pending reserves the slot of the instruction currently being assembled.
    assign occupancy  = {1'b0, queue_count} + {{CNT_BITS{1'b0}}, pending_q};
    assign reserve_ok = (occupancy < (CNT_BITS + 1)'(QUEUE_DEPTH));

    assign instr_valid = (queue_count != '0);
    assign pop         = instr_valid && instr_ready;
    assign rd_ram_en   = issue;
    assign rd_ram_addr = fetch_pc_q;
    assign push_data   = {start_pc_q, asm_d};
    assign instr_pc    = head_data[ENTRY_BITS-1 -: ADDR_BITS];
    assign instr       = head_data[INSTR_BITS-1:0];

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        fetch_pc_d  = fetch_pc_q;
        start_pc_d  = start_pc_q;
        issue_idx_d = issue_idx_q;
        byte_idx_d  = byte_idx_q;
        pending_d   = pending_q;
        rd_vld_d    = 1'b0;
        asm_d       = asm_q;
        push        = 1'b0;

        // armed_q holds off the first read for one cycle after reset release,
        // giving reset the same restart latency as a redirect.
        issue = armed_q && (state_q == FETCH_RUN) && ((issue_idx_q != '0) || reserve_ok);

        case (state_q)
            FETCH_RUN: begin
                if (armed_q && (issue_idx_q == '0) && !reserve_ok) begin
                    state_d = FETCH_STALL;
                end
            end
            FETCH_STALL: begin
                if (reserve_ok) begin
                    state_d = FETCH_RUN;
                end
            end
            default: state_d = FETCH_RUN;
        endcase

        if (rd_vld_q) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (byte_idx_q == IDX_BITS'(i)) begin
                    asm_d[(INSTR_BYTES-1-i)*BYTE_BITS +: BYTE_BITS] = rd_ram_data;
                end
            end
            if (byte_idx_q == LAST_IDX) begin
                push       = 1'b1;
                byte_idx_d = '0;
                pending_d  = 1'b0;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            rd_vld_d   = 1'b1;
            if (issue_idx_q == '0) begin
                start_pc_d = fetch_pc_q;
                pending_d  = 1'b1;
            end
            issue_idx_d = (issue_idx_q == LAST_IDX) ? '0 : issue_idx_q + 1'b1;
        end

        // Redirect wins over everything; a byte returning next cycle is dropped.
        if (redirect_valid) begin
            state_d     = FETCH_RUN;
            fetch_pc_d  = redirect_pc;
            issue_idx_d = '0;
            byte_idx_d  = '0;
            pending_d   = 1'b0;
            rd_vld_d    = 1'b0;
            push        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH_RUN;
            armed_q     <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            start_pc_q  <= '0;
            issue_idx_q <= '0;
            byte_idx_q  <= '0;
            pending_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            fetch_pc_q  <= fetch_pc_d;
            start_pc_q  <= start_pc_d;
            issue_idx_q <= issue_idx_d;
            byte_idx_q  <= byte_idx_d;
            pending_q   <= pending_d;
            rd_vld_q    <= rd_vld_d;
            asm_q       <= asm_d;
        end
    end

    sync_fifo #(
        .WIDTH(ENTRY_BITS),
        .DEPTH(QUEUE_DEPTH)
    ) instr_queue (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_data(head_data),
        .count    (queue_count)
    );

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: byte RAM model, expected-instruction scoreboard
// popped by a monitor on each consumer handshake, plus directed cycle checks.
module tb_instr_prefetch_unit;

    logic        clk;
    logic        reset;
    logic        rd_ram_en;
    logic [7:0]  rd_ram_addr;
    logic [7:0]  rd_ram_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic [2:0]  queue_count;

    logic [7:0]  ram [256];
    logic [23:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    instr_prefetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .rd_ram_en     (rd_ram_en),
        .rd_ram_addr   (rd_ram_addr),
        .rd_ram_data   (rd_ram_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .queue_count   (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_ram_en) rd_ram_data <= ram[rd_ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},  {31'd0, rd_ram_en},   32'd0);
        chk({tag, "_rd_addr"}, {24'd0, rd_ram_addr}, 32'd0);
        chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"},  {16'd0, instr},       32'd0);
        chk({tag, "_pc"},     {24'd0, instr_pc},    32'd0);
        chk({tag, "_count"},  {29'd0, queue_count}, 32'd0);
    endtask

    // Monitor: every accepted head must be the next expected instruction.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && instr_valid && instr_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got pc=%0h instr=%0h want none", instr_pc, instr);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr} !== e) begin
                    bad++;
                    $display("FAIL pop_data: got pc=%0h instr=%0h want pc=%0h instr=%0h",
                             instr_pc, instr, e[23:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'h56; ram[3] = 8'h78;
        reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        repeat (3) tick();
        chk_reset_outputs("rst");

        // 1: reset release, first two instructions
        reset = 1'b0;
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h02, 16'h5678});
        tick();
        chk("t1_issue_en", {31'd0, rd_ram_en}, 32'd1);
        chk("t1_issue_addr", {24'd0, rd_ram_addr}, 32'h00);
        tick(); tick();
        chk("t1_valid_c3", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t1_valid_c4", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr_c4", {16'd0, instr}, 32'h1234);
        instr_ready = 1'b1;
        tick(); tick();
        chk("t1_instr_c6", {16'd0, instr}, 32'h5678);
        chk("t1_pc_c6", {24'd0, instr_pc}, 32'h02);
        tick();

        // 2: fill queue with consumer stalled, then free one slot
        instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        chk("t2_flush_count", {29'd0, queue_count}, 32'd0);
        repeat (11) tick();
        chk("t2_full_count", {29'd0, queue_count}, 32'd4);
        chk("t2_stall_en", {31'd0, rd_ram_en}, 32'd0);
        chk("t2_head_pc", {24'd0, instr_pc}, 32'h00);
        exp_q.push_back({8'h00, 16'h1234});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_pop_count", {29'd0, queue_count}, 32'd3);
        chk("t2_still_stall", {31'd0, rd_ram_en}, 32'd0);
        tick();
        chk("t2_resume_en", {31'd0, rd_ram_en}, 32'd1);
        chk("t2_resume_addr", {24'd0, rd_ram_addr}, 32'h08);
        tick(); tick();
        chk("t2_count_p4", {29'd0, queue_count}, 32'd3);
        tick();
        chk("t2_count_p5", {29'd0, queue_count}, 32'd4);
        chk("t2_head_pc2", {24'd0, instr_pc}, 32'h02);

        // 3: redirect to 0x40 while byte 0 of pc=6 is in flight
        redirect_valid = 1'b1; redirect_pc = 8'h06;
        tick();
        redirect_pc = 8'h40;
        chk("t3_inflight_addr", {24'd0, rd_ram_addr}, 32'h06);
        tick();
        redirect_valid = 1'b0;
        chk("t3_count_t1", {29'd0, queue_count}, 32'd0);
        chk("t3_valid_t1", {31'd0, instr_valid}, 32'd0);
        chk("t3_addr_t1", {24'd0, rd_ram_addr}, 32'h40);
        tick(); tick();
        chk("t3_valid_t3", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t3_pc_t4", {24'd0, instr_pc}, 32'h40);
        chk("t3_instr_t4", {16'd0, instr}, 32'h4041);
        exp_q.push_back({8'h40, 16'h4041});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick(); tick();

        // 4: redirect coincident with push and pop
        chk("t4_head_pc", {24'd0, instr_pc}, 32'h42);
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 8'h80;
        tick();
        redirect_valid = 1'b0;
        chk("t4_count_t1", {29'd0, queue_count}, 32'd0);
        chk("t4_valid_t1", {31'd0, instr_valid}, 32'd0);
        exp_q.push_back({8'h80, 16'h8081});
        tick(); tick(); tick();
        chk("t4_pc_t4", {24'd0, instr_pc}, 32'h80);
        tick();
        instr_ready = 1'b0;

        // 5: instruction spanning the address wrap
        ram[8'hFF] = 8'hAB; ram[8'h00] = 8'hCD;
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr_ff", {24'd0, rd_ram_addr}, 32'hFF);
        tick();
        chk("t5_addr_wrap", {24'd0, rd_ram_addr}, 32'h00);
        tick(); tick();
        chk("t5_instr", {16'd0, instr}, 32'hABCD);
        chk("t5_pc", {24'd0, instr_pc}, 32'hFF);
        exp_q.push_back({8'hFF, 16'hABCD});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;

        // 6: asynchronous reset while byte_idx=1
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        tick(); tick();
        reset = 1'b0;
        exp_q.push_back({8'h00, 16'hCD34});
        tick(); tick(); tick();
        chk("t6_valid_t3", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t6_instr_t4", {16'd0, instr}, 32'hCD34);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
